// File: rtl/writeback_arbiter_pkg.sv
// Shared pipeline constants and the writeback entry layout {float, reg, data}.
// Helpers classify entries for the zero-register rule and the pending-write query.
package writeback_arbiter_pkg;

  localparam int PL_WB_FIFO_DEPTH = 4;
  localparam int PL_REG_ADDR_W    = 6;
  localparam int PL_DATA_W        = 32;

  typedef struct packed {
    logic                     fp;
    logic [PL_REG_ADDR_W-1:0] rd;
    logic [PL_DATA_W-1:0]     data;
  } wb_entry_t;

  // Integer r0 is hardwired; writes to it are dropped but still consume a slot.
  function automatic logic is_int_zero(wb_entry_t e);
    return !e.fp && (e.rd == '0);
  endfunction

  function automatic logic entry_hits(wb_entry_t e, logic [PL_REG_ADDR_W-1:0] rd, logic fp);
    return (e.rd == rd) && (e.fp == fp);
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: ALU/FPU result inputs, decode pending query, register-file write port.
// master drives results and queries; slave is the arbiter.
interface writeback_arbiter_if
  import writeback_arbiter_pkg::*;
#(
  parameter int REG_ADDR_W = PL_REG_ADDR_W,
  parameter int DATA_W     = PL_DATA_W
);

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0]     alu_data;
  logic                  alu_float;

  logic                  fpu_valid;
  logic [REG_ADDR_W-1:0] fpu_reg;
  logic [DATA_W-1:0]     fpu_data;
  logic                  fpu_float;
  logic                  fpu_ready;

  logic [REG_ADDR_W-1:0] chk_reg;
  logic                  chk_float;
  logic                  chk_pending;

  logic [REG_ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0]     writeData;
  logic                  regWrite;
  logic                  float;
  logic                  wb_err;

  modport master (
    output alu_valid, alu_reg, alu_data, alu_float,
    output fpu_valid, fpu_reg, fpu_data, fpu_float,
    output chk_reg, chk_float,
    input  fpu_ready, chk_pending,
    input  writeReg, writeData, regWrite, float, wb_err
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, alu_float,
    input  fpu_valid, fpu_reg, fpu_data, fpu_float,
    input  chk_reg, chk_float,
    output fpu_ready, chk_pending,
    output writeReg, writeData, regWrite, float, wb_err
  );

endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// Circular buffer of pending FPU results with pointers, occupancy and pending-match comparators.
// Caller guarantees no push when full and no pop when empty.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter  int DEPTH = PL_WB_FIFO_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  wb_entry_t                push_dat_i,
  input  logic                     pop_i,
  output wb_entry_t                head_o,
  output logic [CNT_W-1:0]         count_o,
  input  logic [PL_REG_ADDR_W-1:0] chk_reg_i,
  input  logic                     chk_float_i,
  output logic                     chk_hit_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    int off;
    chk_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = (i >= int'(rd_ptr_q)) ? i - int'(rd_ptr_q) : i + DEPTH - int'(rd_ptr_q);
      if (off < int'(count_q) && entry_hits(mem_q[i], chk_reg_i, chk_float_i))
        chk_hit_o = 1'b1;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU (never stalled, top priority) and FPU results onto one registered write port, 1-cycle latency.
// FPU results bypass when the path is idle, else queue; fpu_ready drops while the queue is full.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int WB_FIFO_DEPTH = PL_WB_FIFO_DEPTH,
  parameter int REG_ADDR_W    = PL_REG_ADDR_W,
  parameter int DATA_W        = PL_DATA_W
) (
  input logic               clk,
  input logic               rst,
  writeback_arbiter_if.slave wb
);

  localparam int CNT_W = $clog2(WB_FIFO_DEPTH + 1);

  wb_entry_t         alu_e, fpu_e, head, sel_d;
  logic [CNT_W-1:0]  count;
  logic              fifo_empty, fifo_hit;
  logic              fpu_ready, fpu_acc, bypass, push, pop;
  logic              sel_vld_d, regWrite_d, err_d;

  logic                  regWrite_q;
  logic [REG_ADDR_W-1:0] writeReg_q;
  logic [DATA_W-1:0]     writeData_q;
  logic                  float_q;
  logic                  err_q;

  assign alu_e = '{fp: wb.alu_float, rd: wb.alu_reg, data: wb.alu_data};
  assign fpu_e = '{fp: wb.fpu_float, rd: wb.fpu_reg, data: wb.fpu_data};

  assign fifo_empty = (count == '0);
  // Ready looks only at the current count, so a full queue stays closed even while draining.
  assign fpu_ready  = !rst && (int'(count) < WB_FIFO_DEPTH);
  assign fpu_acc    = wb.fpu_valid && fpu_ready;
  assign bypass     = fpu_acc && !wb.alu_valid && fifo_empty;
  assign push       = fpu_acc && !bypass;
  assign pop        = !wb.alu_valid && !fifo_empty;

  always_comb begin
    sel_vld_d = 1'b0;
    sel_d     = alu_e;
    if (wb.alu_valid) begin
      sel_vld_d = 1'b1;
    end else if (!fifo_empty) begin
      sel_vld_d = 1'b1;
      sel_d     = head;
    end else if (fpu_acc) begin
      sel_vld_d = 1'b1;
      sel_d     = fpu_e;
    end
  end

  assign regWrite_d = sel_vld_d && !is_int_zero(sel_d);
  assign err_d      = err_q || (wb.fpu_valid && !fpu_ready);

  wb_fifo #(
    .DEPTH (WB_FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_dat_i  (fpu_e),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .chk_reg_i   (wb.chk_reg),
    .chk_float_i (wb.chk_float),
    .chk_hit_o   (fifo_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
      float_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      regWrite_q <= regWrite_d;
      err_q      <= err_d;
      if (sel_vld_d) begin
        writeReg_q  <= sel_d.rd;
        writeData_q <= sel_d.data;
        float_q     <= sel_d.fp;
      end
    end
  end

  // A bypassing result is in flight this cycle, so decode must still see it as pending.
  assign wb.chk_pending = fifo_hit || (bypass && entry_hits(fpu_e, wb.chk_reg, wb.chk_float));
  assign wb.fpu_ready   = fpu_ready;
  assign wb.regWrite    = regWrite_q;
  assign wb.writeReg    = writeReg_q;
  assign wb.writeData   = writeData_q;
  assign wb.float       = float_q;
  assign wb.wb_err      = err_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized scoreboard bench: a queue-based reference model predicts each register-file write.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.REG_ADDR_W(6), .DATA_W(32)) wb();

  writeback_arbiter #(
    .WB_FIFO_DEPTH (DEPTH),
    .REG_ADDR_W    (6),
    .DATA_W        (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  typedef struct {
    logic       fp;
    logic [5:0] rd;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    int   cyc;
    ent_t e;
  } exp_t;

  ent_t model_q[$];
  exp_t sb[$];
  bit   err_m;
  int   cyc;
  int   vectors;
  int   miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic expect_write(input ent_t e);
    exp_t x;
    if (!e.fp && e.rd == 6'd0) return;
    x.cyc = cyc + 1;
    x.e   = e;
    sb.push_back(x);
  endtask

  // Drive one cycle at the negedge, check status outputs, advance the model.
  task automatic step(input bit av, input logic [5:0] ar, input logic [31:0] ad, input bit af,
                      input bit fv, input logic [5:0] fr, input logic [31:0] fd, input bit ff,
                      input logic [5:0] cr, input bit cf);
    ent_t a, f;
    bit ready_m, bypass_m, pend_m;
    wb.alu_valid = av; wb.alu_reg = ar; wb.alu_data = ad; wb.alu_float = af;
    wb.fpu_valid = fv; wb.fpu_reg = fr; wb.fpu_data = fd; wb.fpu_float = ff;
    wb.chk_reg   = cr; wb.chk_float = cf;
    #1;
    a = '{af, ar, ad};
    f = '{ff, fr, fd};
    ready_m  = model_q.size() < DEPTH;
    bypass_m = fv && ready_m && !av && model_q.size() == 0;
    pend_m   = bypass_m && f.rd == cr && f.fp == cf;
    foreach (model_q[i]) if (model_q[i].rd == cr && model_q[i].fp == cf) pend_m = 1'b1;
    check("fpu_ready", 32'(wb.fpu_ready), 32'(ready_m));
    check("chk_pending", 32'(wb.chk_pending), 32'(pend_m));
    check("wb_err", 32'(wb.wb_err), 32'(err_m));
    if (av) expect_write(a);
    else if (model_q.size() > 0) expect_write(model_q.pop_front());
    else if (fv && ready_m) expect_write(f);
    if (fv && ready_m && !bypass_m) model_q.push_back(f);
    if (fv && !ready_m) err_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_step(input logic [5:0] cr, input bit cf);
    step(0, 6'd0, 32'd0, 0, 0, 6'd0, 32'd0, 0, cr, cf);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wb.alu_valid = 1'b0;
    wb.fpu_valid = 1'b0;
    #1;
    check("rst_regWrite", 32'(wb.regWrite), 32'd0);
    check("rst_writeReg", 32'(wb.writeReg), 32'd0);
    check("rst_writeData", wb.writeData, 32'd0);
    check("rst_float", 32'(wb.float), 32'd0);
    check("rst_fpu_ready", 32'(wb.fpu_ready), 32'd0);
    check("rst_wb_err", 32'(wb.wb_err), 32'd0);
    model_q.delete();
    sb.delete();
    err_m = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Write-port monitor: every asserted regWrite must match the oldest prediction for this cycle.
  initial begin
    exp_t x;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          x = sb.pop_front();
          vectors++;
          miscompares++;
          $display("FAIL missing_write: got none want reg=%0d data=%0h fp=%0d (due cycle %0d)",
                   x.e.rd, x.e.d, x.e.fp, x.cyc);
        end
        if (wb.regWrite) begin
          vectors++;
          if (sb.size() == 0 || sb[0].cyc != cyc) begin
            miscompares++;
            $display("FAIL unexpected_write: got reg=%0d data=%0h fp=%0d want no write at cycle %0d",
                     wb.writeReg, wb.writeData, wb.float, cyc);
          end else begin
            x = sb.pop_front();
            if (wb.writeReg !== x.e.rd || wb.writeData !== x.e.d || wb.float !== x.e.fp) begin
              miscompares++;
              $display("FAIL write_port: got reg=%0d data=%0h fp=%0d want reg=%0d data=%0h fp=%0d at cycle %0d",
                       wb.writeReg, wb.writeData, wb.float, x.e.rd, x.e.d, x.e.fp, cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    err_m = 1'b0;
    wb.alu_valid = 0; wb.alu_reg = '0; wb.alu_data = '0; wb.alu_float = 0;
    wb.fpu_valid = 0; wb.fpu_reg = '0; wb.fpu_data = '0; wb.fpu_float = 0;
    wb.chk_reg = '0; wb.chk_float = 0;
    @(negedge clk);
    do_reset();

    // Bypass with idle ALU
    step(0, 6'd0, 32'd0, 0, 1, 6'd5, 32'd44, 1, 6'd5, 1);
    idle_step(6'd5, 1);

    // ALU/FPU collision
    step(1, 6'd3, 32'd7, 0, 1, 6'd4, 32'd9, 0, 6'd4, 0);
    idle_step(6'd4, 0);
    idle_step(6'd4, 0);

    // Fill the queue behind continuous ALU traffic, then drain
    for (int i = 0; i < 5; i++)
      step(1, 6'(10 + i), 32'(100 + i), 0, 1, 6'(20 + i), 32'(200 + i), 1'(i), 6'(20 + i), 1'(i));
    for (int i = 0; i < 6; i++) idle_step(6'(20 + i), 1'(i));

    // Integer r0 suppressed, FP r0 written
    step(1, 6'd0, 32'd99, 0, 0, 6'd0, 32'd0, 0, 6'd0, 0);
    step(1, 6'd0, 32'd99, 1, 0, 6'd0, 32'd0, 0, 6'd0, 1);
    idle_step(6'd0, 0);

    // Pending query for FP reg 8 queued behind ALU writes
    step(1, 6'd1, 32'd11, 0, 1, 6'd8, 32'd88, 1, 6'd8, 1);
    step(1, 6'd2, 32'd12, 0, 0, 6'd0, 32'd0, 0, 6'd8, 1);
    step(1, 6'd3, 32'd13, 0, 0, 6'd0, 32'd0, 0, 6'd8, 0);
    idle_step(6'd8, 1);
    idle_step(6'd8, 1);

    // Reset with three entries buffered
    for (int i = 0; i < 3; i++)
      step(1, 6'(30 + i), 32'(300 + i), 0, 1, 6'(40 + i), 32'(400 + i), 0, 6'd40, 0);
    do_reset();
    for (int i = 0; i < 4; i++) idle_step(6'(40 + i), 0);

    // Randomized traffic with periodic resets
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 6, 6'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    while (model_q.size() > 0) idle_step(6'd0, 0);
    repeat (3) idle_step(6'd0, 0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
